// File: rtl/nes_clk_reset_seq_if.sv
// Control/status bundle between the reset sequencer and the rest of the NES core.
// The master side drives lock, soft-reset, region and pause; the slave side is the sequencer.
interface nes_clk_reset_seq_if;
  logic pll_locked;
  logic sys_reset_req;
  logic pal;
  logic pause;
  logic core_reset;
  logic ce_master;
  logic ce_ppu;
  logic ce_cpu;

  modport master (
    output pll_locked, sys_reset_req, pal, pause,
    input  core_reset, ce_master, ce_ppu, ce_cpu
  );

  modport slave (
    input  pll_locked, sys_reset_req, pal, pause,
    output core_reset, ce_master, ce_ppu, ce_cpu
  );
endinterface

// File: rtl/nes_clk_reset_seq.sv
// PLL-lock reset sequencer and NES master/PPU/CPU clock-enable generator on clk_sys.
// Define NES_PAL_EN to build in the PAL divisors (PPU /5, CPU /16) selected by pal_q.
module nes_clk_reset_seq #(
  parameter int LOCK_STABLE = 1024,
  parameter int RST_HOLD    = 64,
  parameter int CLK_DIV     = 4
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  nes_clk_reset_seq_if.slave   bus
);

  localparam int STW = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
  localparam int HW  = (RST_HOLD > 1)    ? $clog2(RST_HOLD)    : 1;
  localparam int MW  = (CLK_DIV > 1)     ? $clog2(CLK_DIV)     : 1;
`ifdef NES_PAL_EN
  localparam int PW  = 3;
`else
  localparam int PW  = 2;
`endif
  localparam int CW  = 4;

  typedef enum logic [1:0] {WAIT_LOCK, STABLE, HOLD, RUN} state_t;

  state_t          state;
  logic [1:0]      lock_pipe;
  logic            lock_s;
  logic [STW-1:0]  st_cnt;
  logic [HW-1:0]   hold_cnt;
  logic [MW-1:0]   m_cnt;
  logic [PW-1:0]   ppu_cnt;
  logic [CW-1:0]   cpu_cnt;
  logic            core_reset_q;
  logic            run_en;
  logic            ce_m;
  logic            tick;
  logic            ppu_last;
  logic            cpu_last;

  // pll_locked is asynchronous to clk_sys
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) lock_pipe <= 2'b00;
    else        lock_pipe <= {lock_pipe[0], bus.pll_locked};
  end
  assign lock_s = lock_pipe[1];

  assign run_en = (state == HOLD) || (state == RUN);
  assign ce_m   = run_en && (m_cnt == MW'(CLK_DIV - 1));
  assign tick   = ce_m && !bus.pause;

`ifdef NES_PAL_EN
  logic pal_q;
  assign ppu_last = ppu_cnt == (pal_q ? 3'd4  : 3'd3);
  assign cpu_last = cpu_cnt == (pal_q ? 4'd15 : 4'd11);
`else
  wire unused_pal = bus.pal;
  assign ppu_last = ppu_cnt == 2'd3;
  assign cpu_last = cpu_cnt == 4'd11;
`endif

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state        <= WAIT_LOCK;
      st_cnt       <= '0;
      hold_cnt     <= '0;
      m_cnt        <= '0;
      ppu_cnt      <= '0;
      cpu_cnt      <= '0;
      core_reset_q <= 1'b1;
`ifdef NES_PAL_EN
      pal_q        <= 1'b0;
`endif
    end else if (!lock_s) begin
      // lock loss overrides everything, including a pending soft reset
      state        <= WAIT_LOCK;
      st_cnt       <= '0;
      hold_cnt     <= '0;
      m_cnt        <= '0;
      ppu_cnt      <= '0;
      cpu_cnt      <= '0;
      core_reset_q <= 1'b1;
    end else begin
      case (state)
        WAIT_LOCK: begin
          state  <= STABLE;
          st_cnt <= '0;
        end
        STABLE: begin
          if (st_cnt == STW'(LOCK_STABLE - 1)) begin
            state    <= HOLD;
            hold_cnt <= '0;
`ifdef NES_PAL_EN
            pal_q    <= bus.pal;
`endif
          end else begin
            st_cnt <= st_cnt + 1'b1;
          end
        end
        default: begin  // HOLD or RUN: dividers running
          if (bus.sys_reset_req) begin
            state        <= HOLD;
            hold_cnt     <= '0;
            m_cnt        <= '0;
            ppu_cnt      <= '0;
            cpu_cnt      <= '0;
            core_reset_q <= 1'b1;
`ifdef NES_PAL_EN
            if (state == RUN) pal_q <= bus.pal;
`endif
          end else begin
            if (state == HOLD) begin
              if (hold_cnt == HW'(RST_HOLD - 1)) begin
                state        <= RUN;
                core_reset_q <= 1'b0;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
            m_cnt <= ce_m ? '0 : m_cnt + 1'b1;
            // pause freezes the PPU/CPU phase, master keeps ticking
            if (tick) begin
              ppu_cnt <= ppu_last ? '0 : ppu_cnt + 1'b1;
              cpu_cnt <= cpu_last ? '0 : cpu_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.core_reset = core_reset_q;
  assign bus.ce_master  = ce_m;
  assign bus.ce_ppu     = tick && (ppu_cnt == '0);
  assign bus.ce_cpu     = tick && (cpu_cnt == '0);

endmodule

// File: tb/tb_nes_clk_reset_seq.sv
// Bench for nes_clk_reset_seq: directed timing scenarios plus randomized lock/soft-reset/pause
// traffic checked against an event-age reference model.
module tb_nes_clk_reset_seq;
  localparam int LS = 8;
  localparam int RH = 4;
  localparam int CD = 4;
`ifdef NES_PAL_EN
  localparam bit PAL_EN = 1'b1;
`else
  localparam bit PAL_EN = 1'b0;
`endif

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  int   n_cmp   = 0;
  int   n_err   = 0;

  nes_clk_reset_seq_if bus();

  nes_clk_reset_seq #(.LOCK_STABLE(LS), .RST_HOLD(RH), .CLK_DIV(CD)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  logic [3:0] outs;
  assign outs = {bus.core_reset, bus.ce_master, bus.ce_ppu, bus.ce_cpu};

  // Reference model: lock-run length, ages since the last hold start, and count of
  // unpaused master ticks; enables follow from modulo arithmetic on those ages.
  int   m_lk, m_age, m_hage, m_tk;
  logic m_ls1, m_ls, m_palq;
  logic m_act, exp_rst, exp_cm, exp_ppu, exp_cpu;
  logic [3:0] exp_outs;
  int   pdiv, cdiv;

  assign pdiv     = m_palq ? 5 : 4;
  assign cdiv     = m_palq ? 16 : 12;
  assign m_act    = m_lk > LS;
  assign exp_rst  = !(m_act && m_hage >= RH);
  assign exp_cm   = m_act && (m_age % CD == CD - 1);
  assign exp_ppu  = exp_cm && !bus.pause && (m_tk % pdiv == 0);
  assign exp_cpu  = exp_cm && !bus.pause && (m_tk % cdiv == 0);
  assign exp_outs = {exp_rst, exp_cm, exp_ppu, exp_cpu};

  always @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      m_ls1 <= 1'b0; m_ls <= 1'b0; m_palq <= 1'b0;
      m_lk <= 0; m_age <= 0; m_hage <= 0; m_tk <= 0;
    end else begin
      m_ls1 <= bus.pll_locked;
      m_ls  <= m_ls1;
      if (!m_ls) begin
        m_lk <= 0; m_age <= 0; m_hage <= 0; m_tk <= 0;
      end else if (m_lk == LS || (m_act && bus.sys_reset_req)) begin
        m_lk <= LS + 1; m_age <= 0; m_hage <= 0; m_tk <= 0;
        if (!(m_act && m_hage < RH)) m_palq <= PAL_EN && bus.pal;
      end else if (m_act) begin
        m_age <= m_age + 1;
        if (m_hage < RH) m_hage <= m_hage + 1;
        if (exp_cm && !bus.pause) m_tk <= m_tk + 1;
      end else begin
        m_lk <= m_lk + 1;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    bus.pll_locked = 1'b1; bus.sys_reset_req = 1'b0; bus.pal = 1'b0; bus.pause = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    n_cmp++;
    if (outs !== 4'b1000) begin
      n_err++; $display("FAIL reset_state: got %b exp 1000", outs);
    end
  endtask

  task automatic test_power_up();
    logic [3:0] e_v;
    @(negedge clk_sys); rst_n = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk_sys); #1;
      e_v = {(e < 15), (e == 14), (e == 14), (e == 14)};
      n_cmp++;
      if (outs !== e_v) begin
        n_err++; $display("FAIL power_up edge %0d: got %b exp %b", e, outs, e_v);
      end
    end
  endtask

  task automatic test_ntsc_ratios();
    int nm = 0, np = 0, nc = 0, orphan = 0;
    repeat (480) begin
      @(posedge clk_sys); #1;
      nm += int'(bus.ce_master); np += int'(bus.ce_ppu); nc += int'(bus.ce_cpu);
      if (bus.ce_cpu && !bus.ce_ppu) orphan++;
    end
    n_cmp += 4;
    if (nm !== 120) begin n_err++; $display("FAIL ntsc_master: got %0d exp 120", nm); end
    if (np !== 30)  begin n_err++; $display("FAIL ntsc_ppu: got %0d exp 30", np); end
    if (nc !== 10)  begin n_err++; $display("FAIL ntsc_cpu: got %0d exp 10", nc); end
    if (orphan !== 0) begin n_err++; $display("FAIL ntsc_cpu_align: got %0d exp 0", orphan); end
  endtask

  task automatic test_soft_reset();
    logic [3:0] e_v;
    @(negedge clk_sys); bus.sys_reset_req = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk_sys); #1;
      n_cmp++;
      if (outs !== 4'b1000) begin
        n_err++; $display("FAIL soft_req_held cyc %0d: got %b exp 1000", i, outs);
      end
    end
    @(negedge clk_sys); bus.sys_reset_req = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk_sys); #1;
      e_v = {(e < 4), (e == 3), (e == 3), (e == 3)};
      n_cmp++;
      if (outs !== e_v) begin
        n_err++; $display("FAIL soft_release edge %0d: got %b exp %b", e, outs, e_v);
      end
    end
  endtask

  task automatic test_pause();
    int nm = 0, nq = 0;
    @(negedge clk_sys); bus.pause = 1'b1;
    repeat (100) begin
      @(posedge clk_sys); #1;
      nm += int'(bus.ce_master); nq += int'(bus.ce_ppu) + int'(bus.ce_cpu);
    end
    n_cmp += 2;
    if (nm !== 25) begin n_err++; $display("FAIL pause_master: got %0d exp 25", nm); end
    if (nq !== 0)  begin n_err++; $display("FAIL pause_gated: got %0d exp 0", nq); end
    @(negedge clk_sys); bus.pause = 1'b0;
    repeat (200) begin
      @(negedge clk_sys);
      n_cmp++;
      if (outs !== exp_outs) begin
        n_err++; $display("FAIL pause_resume t=%0t: got %b exp %b", $time, outs, exp_outs);
      end
    end
  endtask

  task automatic test_pal();
    int k = 0, nm = 0, np = 0, nc = 0;
    int ep = PAL_EN ? 48 : 60;
    int ec = PAL_EN ? 15 : 20;
    @(negedge clk_sys); bus.pal = 1'b1; bus.sys_reset_req = 1'b1;
    @(negedge clk_sys); bus.sys_reset_req = 1'b0;
    while (bus.core_reset !== 1'b0 && k < 50) begin
      @(posedge clk_sys); #1; k++;
    end
    n_cmp++;
    if (bus.core_reset !== 1'b0) begin
      n_err++; $display("FAIL pal_run_wait: core_reset got %b exp 0", bus.core_reset);
    end
    repeat (960) begin
      @(posedge clk_sys); #1;
      nm += int'(bus.ce_master); np += int'(bus.ce_ppu); nc += int'(bus.ce_cpu);
      bus.pal = 1'($urandom_range(0, 1));
    end
    n_cmp += 3;
    if (nm !== 240) begin n_err++; $display("FAIL pal_master: got %0d exp 240", nm); end
    if (np !== ep)  begin n_err++; $display("FAIL pal_ppu: got %0d exp %0d", np, ep); end
    if (nc !== ec)  begin n_err++; $display("FAIL pal_cpu: got %0d exp %0d", nc, ec); end
    bus.pal = 1'b0;
  endtask

  task automatic test_lock_glitch();
    logic [3:0] e_v;
    @(negedge clk_sys); rst_n = 1'b0;
    @(negedge clk_sys); rst_n = 1'b1; bus.pll_locked = 1'b1;
    repeat (6) @(posedge clk_sys);
    @(negedge clk_sys); bus.pll_locked = 1'b0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys); bus.pll_locked = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk_sys); #1;
      e_v = {(e < 15), (e == 14), (e == 14), (e == 14)};
      n_cmp++;
      if (outs !== e_v) begin
        n_err++; $display("FAIL lock_glitch edge %0d: got %b exp %b", e, outs, e_v);
      end
    end
  endtask

  task automatic test_random();
    int lk_dn = 0, rq_dn = 0;
    repeat (3000) begin
      @(negedge clk_sys);
      n_cmp++;
      if (outs !== exp_outs) begin
        n_err++; $display("FAIL random t=%0t: got %b exp %b", $time, outs, exp_outs);
      end
      if (lk_dn > 0) begin
        lk_dn--;
        if (lk_dn == 0) bus.pll_locked = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        bus.pll_locked = 1'b0; lk_dn = $urandom_range(1, 4);
      end
      if (rq_dn > 0) begin
        rq_dn--;
        if (rq_dn == 0) bus.sys_reset_req = 1'b0;
      end else if ($urandom_range(0, 79) == 0) begin
        bus.sys_reset_req = 1'b1; rq_dn = $urandom_range(1, 12);
      end
      if ($urandom_range(0, 39) == 0) bus.pause = ~bus.pause;
      bus.pal = 1'($urandom_range(0, 1));
    end
    @(negedge clk_sys);
    bus.pll_locked = 1'b1; bus.sys_reset_req = 1'b0; bus.pause = 1'b0;
  endtask

  task automatic test_async_reset();
    int k = 0;
    while (bus.core_reset !== 1'b0 && k < 60) begin
      @(posedge clk_sys); #1; k++;
    end
    n_cmp++;
    if (bus.core_reset !== 1'b0) begin
      n_err++; $display("FAIL async_pre_run: core_reset got %b exp 0", bus.core_reset);
    end
    @(posedge clk_sys); #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (outs !== 4'b1000) begin
      n_err++; $display("FAIL async_reset: got %b exp 1000", outs);
    end
    #20;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_ntsc_ratios();
    test_soft_reset();
    test_pause();
    test_pal();
    test_lock_glitch();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
